// File: rtl/caf_frame_streamer.sv
// Purpose: buffers one frame of buffer_length I/Q samples, then streams it out over valid/ready.
// Latency: first sample valid 1 cycle after the final write; one sample per cycle while ready.
// Backpressure: s_axis_tready=0 holds the output sample; wr_ready=0 during streaming (writes ignored).
module caf_frame_streamer #(
    parameter int buffer_length    = 10,
    parameter int index_bits       = 4,
    parameter int i_bits           = 12,
    parameter int q_bits           = 12,
    parameter int frame_count_bits = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          wr_en,
    input  logic signed [i_bits-1:0]      wr_i,
    input  logic signed [q_bits-1:0]      wr_q,
    output logic                          wr_ready,
    output logic                          m_axis_tvalid,
    input  logic                          s_axis_tready,
    output logic signed [i_bits-1:0]      xi,
    output logic signed [q_bits-1:0]      xq,
    output logic [index_bits-1:0]         index,
    output logic                          m_axis_tlast,
    output logic [frame_count_bits-1:0]   frame_count
);

    localparam logic [index_bits-1:0]       LAST_IDX = index_bits'(buffer_length - 1);
    localparam logic [index_bits-1:0]       IDX_ONE  = index_bits'(1);
    localparam logic [frame_count_bits-1:0] FC_ONE   = frame_count_bits'(1);

    typedef enum logic {
        FILL   = 1'b0,
        STREAM = 1'b1
    } state_t;

    typedef struct packed {
        logic signed [i_bits-1:0] i;
        logic signed [q_bits-1:0] q;
    } sample_t;

    state_t                        state_q;
    sample_t                       mem_q [buffer_length];
    logic [index_bits-1:0]         wr_ptr_q;
    logic [index_bits-1:0]         rd_ptr_q;
    logic [index_bits-1:0]         rd_ptr_d;
    logic                          wr_ready_q;
    logic                          tvalid_q;
    logic                          tlast_q;
    logic signed [i_bits-1:0]      xi_q;
    logic signed [q_bits-1:0]      xq_q;
    logic [frame_count_bits-1:0]   frame_count_q;

    logic    wr_accept;
    logic    xfer;
    sample_t next_sample;
    sample_t first_sample;

    // wr_ready_q is high exactly while filling, so it alone gates writes.
    assign wr_accept    = wr_en && wr_ready_q;
    assign xfer         = tvalid_q && s_axis_tready;
    assign rd_ptr_d     = rd_ptr_q + IDX_ONE;
    assign next_sample  = mem_q[rd_ptr_d];
    // Sample 0 is always written before the final write because buffer_length >= 2.
    assign first_sample = mem_q[0];

    // Sample storage: written only on accepted writes, never reset.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= '{i: wr_i, q: wr_q};
        end
    end

    // Fill/stream sequencer with registered handshake and data outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= FILL;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            wr_ready_q    <= 1'b1;
            tvalid_q      <= 1'b0;
            tlast_q       <= 1'b0;
            xi_q          <= '0;
            xq_q          <= '0;
            frame_count_q <= '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (wr_accept) begin
                        if (wr_ptr_q == LAST_IDX) begin
                            // Frame complete: present sample 0 on the next cycle.
                            wr_ptr_q   <= '0;
                            rd_ptr_q   <= '0;
                            state_q    <= STREAM;
                            wr_ready_q <= 1'b0;
                            tvalid_q   <= 1'b1;
                            tlast_q    <= (LAST_IDX == '0);
                            xi_q       <= first_sample.i;
                            xq_q       <= first_sample.q;
                        end else begin
                            wr_ptr_q <= wr_ptr_q + IDX_ONE;
                        end
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        if (tlast_q) begin
                            // Last sample taken: back to filling, xi/xq keep their value.
                            rd_ptr_q      <= '0;
                            state_q       <= FILL;
                            wr_ready_q    <= 1'b1;
                            tvalid_q      <= 1'b0;
                            tlast_q       <= 1'b0;
                            frame_count_q <= frame_count_q + FC_ONE;
                        end else begin
                            rd_ptr_q <= rd_ptr_d;
                            tlast_q  <= (rd_ptr_d == LAST_IDX);
                            xi_q     <= next_sample.i;
                            xq_q     <= next_sample.q;
                        end
                    end
                end
                default: begin
                    state_q <= FILL;
                end
            endcase
        end
    end

    assign wr_ready      = wr_ready_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign xi            = xi_q;
    assign xq            = xq_q;
    assign index         = rd_ptr_q;
    assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_caf_frame_streamer.sv
// Purpose: directed + randomized checks of caf_frame_streamer against a frame-queue model.
// Latency: expects first valid one cycle after the last write, no bubbles while ready.
// Backpressure: drives s_axis_tready always-on, patterned, or random and expects held outputs.
module tb_caf_frame_streamer;

    localparam int L  = 10;
    localparam int IB = 4;
    localparam int IW = 12;
    localparam int QW = 12;
    localparam int FB = 8;

    logic                 clk;
    logic                 reset_n;
    logic                 wr_en;
    logic signed [IW-1:0] wr_i;
    logic signed [QW-1:0] wr_q;
    logic                 wr_ready;
    logic                 m_axis_tvalid;
    logic                 s_axis_tready;
    logic signed [IW-1:0] xi;
    logic signed [QW-1:0] xq;
    logic [IB-1:0]        index;
    logic                 m_axis_tlast;
    logic [FB-1:0]        frame_count;

    int checks = 0;
    int errors = 0;

    // Reference model: the frame as plain integer arrays and a modular frame counter.
    int exp_i [L];
    int exp_q [L];
    int fc_model = 0;

    caf_frame_streamer #(
        .buffer_length(L), .index_bits(IB), .i_bits(IW), .q_bits(QW), .frame_count_bits(FB)
    ) dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_i(wr_i), .wr_q(wr_q),
        .wr_ready(wr_ready), .m_axis_tvalid(m_axis_tvalid), .s_axis_tready(s_axis_tready),
        .xi(xi), .xq(xq), .index(index), .m_axis_tlast(m_axis_tlast), .frame_count(frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rand_frame();
        for (int k = 0; k < L; k++) begin
            exp_i[k] = int'($urandom_range(0, 4095)) - 2048;
            exp_q[k] = int'($urandom_range(0, 4095)) - 2048;
        end
    endtask

    // Writes exp_i/exp_q with wr_en held high, then leaves the bench at the negedge
    // one cycle after the final write, where sample 0 must already be valid.
    task automatic fill_frame();
        for (int k = 0; k < L; k++) begin
            @(negedge clk);
            chk("fill_wr_ready", 32'(wr_ready), 32'd1);
            chk("fill_tvalid_low", 32'(m_axis_tvalid), 32'd0);
            wr_en = 1'b1;
            wr_i  = IW'(exp_i[k]);
            wr_q  = QW'(exp_q[k]);
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // mode 0: ready always, 1: pattern 1,0,0, 2: random. junk: pulse writes while streaming.
    // limit: number of transfers to perform (L for a full frame).
    task automatic stream_frame(input int mode, input bit junk, input int limit);
        int idx = 0;
        int cyc = 0;
        bit rdy;
        while (idx < limit && cyc < 200) begin
            chk("st_tvalid", 32'(m_axis_tvalid), 32'd1);
            chk("st_wr_ready", 32'(wr_ready), 32'd0);
            chk("st_index", 32'(index), 32'(idx));
            chk("st_xi", 32'(xi), 32'(exp_i[idx]));
            chk("st_xq", 32'(xq), 32'(exp_q[idx]));
            chk("st_tlast", 32'(m_axis_tlast), 32'(idx == L - 1));
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ((cyc % 3) == 0);
                default: rdy = ($urandom_range(0, 9) < 6);
            endcase
            s_axis_tready = rdy;
            if (junk) begin
                wr_en = $urandom_range(0, 1) == 1;
                wr_i  = 12'h7FF;
                wr_q  = 12'h800;
            end
            @(negedge clk);
            wr_en = 1'b0;
            if (rdy) idx++;
            cyc++;
        end
        s_axis_tready = 1'b0;
        if (cyc >= 200) chk("stream_timeout", 32'(idx), 32'(limit));
        if (limit == L) begin
            fc_model = (fc_model + 1) % 256;
            chk("end_tvalid", 32'(m_axis_tvalid), 32'd0);
            chk("end_tlast", 32'(m_axis_tlast), 32'd0);
            chk("end_wr_ready", 32'(wr_ready), 32'd1);
            chk("end_frame_count", 32'(frame_count), 32'(fc_model));
            chk("end_xi_hold", 32'(xi), 32'(exp_i[L-1]));
            chk("end_xq_hold", 32'(xq), 32'(exp_q[L-1]));
        end
    endtask

    initial begin
        reset_n = 1'b0;
        wr_en = 1'b0;
        wr_i = '0;
        wr_q = '0;
        s_axis_tready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_tlast", 32'(m_axis_tlast), 32'd0);
        chk("rst_xi", 32'(xi), 32'd0);
        chk("rst_xq", 32'(xq), 32'd0);
        chk("rst_index", 32'(index), 32'd0);
        chk("rst_frame_count", 32'(frame_count), 32'd0);
        reset_n = 1'b1;

        // 1: ramp frame (k,-k), ready always high.
        for (int k = 0; k < L; k++) begin
            exp_i[k] = k;
            exp_q[k] = -k;
        end
        fill_frame();
        stream_frame(0, 1'b0, L);

        // 2: same frame, ready stalls 1,0,0.
        fill_frame();
        stream_frame(1, 1'b0, L);

        // 3: random frame, ignored writes of 0x7FF/0x800 during streaming; next frame must be clean.
        rand_frame();
        fill_frame();
        stream_frame(2, 1'b1, L);
        rand_frame();
        fill_frame();
        stream_frame(2, 1'b0, L);

        // 4: extremes at index 5.
        rand_frame();
        exp_i[5] = -2048;
        exp_q[5] = 2047;
        fill_frame();
        stream_frame(2, 1'b0, L);

        // 5: async reset after 4 transfers.
        rand_frame();
        fill_frame();
        stream_frame(0, 1'b0, 4);
        #2 reset_n = 1'b0;
        #1;
        fc_model = 0;
        chk("mid_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("mid_rst_tlast", 32'(m_axis_tlast), 32'd0);
        chk("mid_rst_xi", 32'(xi), 32'd0);
        chk("mid_rst_xq", 32'(xq), 32'd0);
        chk("mid_rst_index", 32'(index), 32'd0);
        chk("mid_rst_frame_count", 32'(frame_count), 32'd0);
        chk("mid_rst_wr_ready", 32'(wr_ready), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        rand_frame();
        fill_frame();
        stream_frame(2, 1'b0, L);

        // 6: 256 back-to-back frames, counter wraps.
        for (int f = 0; f < 256; f++) begin
            rand_frame();
            fill_frame();
            stream_frame(($urandom_range(0, 3) == 0) ? 2 : 0, 1'b0, L);
            if (fc_model == 0) chk("fc_wrap_zero", 32'(frame_count), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
